// File: rtl/pong_pkg.sv
// Shared tile geometry and tile code constants for game, layer1 and the tile update queue.
package pong_pkg;

    localparam int TILE_ADDR_W      = 5;
    localparam int TILE_DATA_W      = 8;
    localparam int TILE_QUEUE_DEPTH = 8;

    localparam logic [TILE_DATA_W-1:0] TILE_BLANK  = 8'h00;
    localparam logic [TILE_DATA_W-1:0] TILE_BALL   = 8'h01;
    localparam logic [TILE_DATA_W-1:0] TILE_PADDLE = 8'h02;
    localparam logic [TILE_DATA_W-1:0] TILE_WALL   = 8'h03;
    localparam logic [TILE_DATA_W-1:0] TILE_DIGIT0 = 8'h10;

endpackage

// File: rtl/tile_queue_match.sv
// Finds the youngest pending queue entry whose address equals the request address.
// The head entry is masked out when it is being popped in the same cycle.
module tile_queue_match #(
    parameter int DEPTH  = pong_pkg::TILE_QUEUE_DEPTH,
    parameter int ADDR_W = pong_pkg::TILE_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic [DEPTH*ADDR_W-1:0] entry_addr,
    input  logic [PTR_W-1:0]        rd_ptr,
    input  logic [CNT_W-1:0]        count,
    input  logic                    pop,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    hit,
    output logic [PTR_W-1:0]        hit_idx
);

    logic [PTR_W-1:0] idx_s;

    // Walk from head to tail so the last match seen is the youngest.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx_s   = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && !(pop && (k == 0)) &&
                (entry_addr[idx_s*ADDR_W +: ADDR_W] == req_addr)) begin
                hit     = 1'b1;
                hit_idx = idx_s;
            end else begin
                hit     = hit;
                hit_idx = hit_idx;
            end
        end
    end

endmodule

// File: rtl/tile_update_queue.sv
// Buffers tile RAM updates and commits them only while vertical blanking is high.
// Optional in-place coalescing of same-address updates: define TILE_QUEUE_COALESCE_EN.
module tile_update_queue
    import pong_pkg::*;
#(
    parameter int DEPTH  = TILE_QUEUE_DEPTH,
    parameter int ADDR_W = TILE_ADDR_W,
    parameter int DATA_W = TILE_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vblank,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_req_ready,
    output logic [ADDR_W-1:0] o_ram_address,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_ram_wren,
    output logic [CNT_W-1:0]  o_level
);

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] ram_address_r;
    logic [DATA_W-1:0] ram_data_r;
    logic              ram_wren_r;
    logic              push_s;
    logic              pop_s;
    logic              enq_s;
    logic              hit_s;
    logic [PTR_W-1:0]  hit_idx_s;

    assign o_req_ready   = (count_r != CNT_W'(DEPTH));
    assign push_s        = i_req_valid && o_req_ready;
    assign pop_s         = i_vblank && (count_r != {CNT_W{1'b0}});
    assign enq_s         = push_s && !hit_s;
    assign o_ram_address = ram_address_r;
    assign o_ram_data    = ram_data_r;
    assign o_ram_wren    = ram_wren_r;
    assign o_level       = count_r;

`ifdef TILE_QUEUE_COALESCE_EN
    logic [DEPTH*ADDR_W-1:0] addr_flat_s;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign addr_flat_s[g*ADDR_W +: ADDR_W] = addr_mem_r[g];
    end

    tile_queue_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .entry_addr (addr_flat_s),
        .rd_ptr     (rd_ptr_r),
        .count      (count_r),
        .pop        (pop_s),
        .req_addr   (i_req_addr),
        .hit        (hit_s),
        .hit_idx    (hit_idx_s)
    );
`else
    assign hit_s     = 1'b0;
    assign hit_idx_s = {PTR_W{1'b0}};
`endif

    // Entry count after this edge's enqueue and pop.
    always_comb begin
        count_next_s = count_r;
        case ({enq_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Queue storage, pointers and the registered RAM write port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_W{1'b0}};
                data_mem_r[i] <= {DATA_W{1'b0}};
            end
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            ram_address_r <= {ADDR_W{1'b0}};
            ram_data_r    <= {DATA_W{1'b0}};
            ram_wren_r    <= 1'b0;
        end else begin
            if (push_s && hit_s) begin
                data_mem_r[hit_idx_s] <= i_req_data;
            end else if (enq_s) begin
                addr_mem_r[wr_ptr_r] <= i_req_addr;
                data_mem_r[wr_ptr_r] <= i_req_data;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                ram_address_r <= addr_mem_r[rd_ptr_r];
                ram_data_r    <= data_mem_r[rd_ptr_r];
                rd_ptr_r      <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            ram_wren_r <= pop_s;
            count_r    <= count_next_s;
        end
    end

endmodule

// File: doc/tile_update_queue.md
# tile_update_queue

Write-buffer between the `game` control block and port B of the tile RAM (`RAM_2PORT`). It accepts tile updates (address, code) at any time and commits them to the RAM only during vertical blanking, so `layer1` never reads a partly updated frame. It runs in the `i_clk` domain. `i_vblank` arrives from a synchronised lcd_driver flag.

## Interface
- `DEPTH`, 8: queue entries; power of two, 2–32.
- `ADDR_W`, 5: tile RAM address width.
- `DATA_W`, 8: tile RAM data width.

- `i_clk`  in  1  system clock; all logic rises on it.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_vblank`  in  1  high while the display is in vertical blanking; synchronous to `i_clk`.
- `i_req_valid`  in  1  update request from `game`.
- `i_req_addr`  in  ADDR_W  tile address.
- `i_req_data`  in  DATA_W  tile code.
- `o_req_ready`  out  1  queue can accept a request this cycle.
- `o_ram_address`  out  ADDR_W  RAM write address.
- `o_ram_data`  out  DATA_W  RAM write data.
- `o_ram_wren`  out  1  RAM write strobe, one cycle per entry.
- `o_level`  out  $clog2(DEPTH)+1  current entry count.

## Operation
- **Storage:** circular FIFO with read pointer, write pointer and count. Pointers wrap modulo DEPTH. Count runs 0..DEPTH.
- **Accept:** a request is accepted when `i_req_valid && o_req_ready` at a rising edge.
  - `o_req_ready = (count != DEPTH)`, decoded from registered count only.
  - A pop in the same cycle does not raise ready.
- **Drain:** at each edge where `i_vblank` is high and count > 0, pop the head entry.
  - Drive its address and data on `o_ram_address` and `o_ram_data`, and set `o_ram_wren` for that cycle.
  - Throughput is one write per cycle.
- **Idle:** when nothing is popped, `o_ram_wren` is 0. Address and data hold their last values.
- **Simultaneous push and pop:** count stays the same and both pointers advance.
- **Order:** entries reach the RAM in acceptance order.
- **End of blanking:** when `i_vblank` falls, draining stops at that edge. Remaining entries wait for the next blanking interval and are never lost.
- **Empty queue:** no write is issued, even while `i_vblank` is high.
- **Reset:** while `i_rst_n` is low, pointers and count are 0, `o_ram_wren` = 0, `o_ram_address` = 0, `o_ram_data` = 0, `o_level` = 0. Reset during a blanking drain discards all pending entries, with no partial write.

## Timing
- **Minimum latency:** if a request is accepted at edge N into an empty queue and `i_vblank` is high at N+1, `o_ram_wren` is high after edge N+1.
- **Registered outputs:** `o_ram_*` and `o_level` are all registered. `o_level` reflects an edge's push/pop after that edge.
- **Ready:** `o_req_ready` is combinational from count, with no path from `i_req_valid`.
- **Worst-case drain:** a full queue empties in DEPTH cycles of blanking. At 8 entries this is far inside one blanking interval.

## Configuration
- **`TILE_QUEUE_COALESCE_EN` defined:**
  - An accepted request whose address matches a pending entry overwrites that entry's data in place. Count is unchanged and the original queue position is kept.
  - If several entries match, the youngest is overwritten.
  - The head entry being popped that same cycle is excluded from matching; in that case the request enqueues normally.
  - Ready rule is unchanged (ready = !full).
- **Not defined:** every accepted request occupies a new entry. Duplicate addresses are written in order, so the last one wins in RAM.

## Structure
- **Package `pong_pkg`:** holds `TILE_ADDR_W` = 5, `TILE_DATA_W` = 8 and the tile code constants shared with `game` and `layer1`. Parameter defaults come from it.
- **Sub-module `tile_queue_match`** (present only under `TILE_QUEUE_COALESCE_EN`):
  - Compares the request address against the valid entries, with the popping head masked out.
  - Returns hit plus the youngest hit index.
- **Core:** FIFO, pointers and output registers stay in `tile_update_queue`.

## Test plan
- **Reset values:** after reset, `o_req_ready` = 1, `o_level` = 0 and `o_ram_wren` = 0. Pulse `i_rst_n` low mid-drain → `o_ram_wren` drops immediately and the queue is empty.
- **Held until blanking:** push (3, 0x11), then (7, 0x22) with `i_vblank` = 0 → no writes and `o_level` = 2. Raise `i_vblank` → writes (3, 0x11) then (7, 0x22) on consecutive cycles, then `o_level` = 0.
- **Full queue:** push 8 entries with `i_vblank` = 0 → `o_req_ready` = 0 and a 9th valid request is not accepted. After one blanking pop, ready = 1 again.
- **Blanking falls mid-drain:** 4 entries, `i_vblank` high for 2 cycles → exactly 2 writes. The next blanking writes the remaining 2, in order.
- **Push and pop together:** level 3 plus a simultaneous push and pop → level stays 3 and the RAM order is preserved.
- **Coalescing:**
  - With `TILE_QUEUE_COALESCE_EN`: push (5, 0xA0), (9, 0xB0), (5, 0xC0) → `o_level` = 2, writes (5, 0xC0), (9, 0xB0).
  - Without it: `o_level` = 3, writes (5, 0xA0), (9, 0xB0), (5, 0xC0).
